// File: rtl/fp_mac_pkg.sv
// Shared MAC floating-point definitions: field widths, packed-float layout and
// special-value constants used by the adder back end.
package fp_mac_pkg;

   localparam int unsigned EXP_W    = 8;
   localparam int unsigned MANT_W   = 23;
   localparam int unsigned SUM_W    = MANT_W + 2;
   localparam int unsigned EXP_BIAS = 127;

   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] frac;
   } fp_t;

   localparam fp_t FP_POS_ZERO = '0;

   // Infinity with the given sign.
   function automatic fp_t fp_inf(input logic sign);
      fp_t r;
      r.sign = sign;
      r.exp  = EXP_MAX;
      r.frac = '0;
      return r;
   endfunction

   // Zero keeping the given sign (used for flushed underflow).
   function automatic fp_t fp_signed_zero(input logic sign);
      fp_t r;
      r.sign = sign;
      r.exp  = '0;
      r.frac = '0;
      return r;
   endfunction

endpackage

// File: rtl/lzc25.sv
// Combinational leading-zero counter over a 25-bit word. The count saturates
// at 24, so an all-zero input reports 24.
module lzc25 (
   input  logic [24:0] data,
   output logic [4:0]  count
);

   // Scan upward so the highest set bit is the last one to write the count.
   always_comb begin
      count = 5'd24;
      for (int i = 0; i < 25; i++) begin
         if (data[i]) begin
            count = 5'(24 - i);
         end
      end
   end

endmodule

// File: rtl/step3_normalize_pack.sv
// Normalize-and-pack back end of the MAC adder path. Stage 1 classifies the raw
// aligned sum (sign, carry, zero, inf, leading-zero count); stage 2 normalizes,
// adjusts the exponent, saturates overflow, flushes underflow and packs an
// IEEE-754 single. Valid/ready handshake with full-throughput backpressure.
// Optional: define STATUS_FLAGS_EN to add out_flags = {overflow, underflow, zero}.
module step3_normalize_pack
   import fp_mac_pkg::*;
(
   input  logic              clock,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign_in1,
   input  logic              in_sign_in2,
   input  logic [EXP_W-1:0]  in_current_ex,
   input  logic [SUM_W-1:0]  in_mant_sum,
   input  logic              in_sum_neg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_result
`ifdef STATUS_FLAGS_EN
   ,
   output logic [2:0]        out_flags
`endif
);

   // Stage-1 registers
   logic              s1_valid;
   logic              s1_sign;
   logic              s1_carry;
   logic              s1_zero;
   logic              s1_inf;
   logic [4:0]        s1_lz;
   logic [EXP_W-1:0]  s1_exp;
   logic [MANT_W:0]   s1_sum;

   // Stage-2 registers
   logic              s2_valid;
   fp_t               s2_result;

   logic              s1_adv;
   logic              s2_adv;
   logic [4:0]        lz_in;

   logic [8:0]        exp_inc;
   logic signed [8:0] exp_norm;
   logic [MANT_W-1:0] frac_norm;
   fp_t               res_d;

   assign s2_adv     = !s2_valid || out_ready;
   assign s1_adv     = !s1_valid || s2_adv;
   assign in_ready   = s1_adv;
   assign out_valid  = s2_valid;
   assign out_result = s2_result;

   // Carry bit is excluded; a zero low field pads to 25 bits and reports 24.
   lzc25 u_lzc (
      .data  ({in_mant_sum[MANT_W:0], 1'b0}),
      .count (lz_in)
   );

   // Stage 1: capture classification of the incoming sum.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_carry <= 1'b0;
         s1_zero  <= 1'b0;
         s1_inf   <= 1'b0;
         s1_lz    <= '0;
         s1_exp   <= '0;
         s1_sum   <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign  <= in_sum_neg ? in_sign_in2 : in_sign_in1;
            s1_carry <= in_mant_sum[SUM_W-1];
            s1_zero  <= (in_mant_sum == '0);
            s1_inf   <= (in_current_ex == EXP_MAX);
            s1_lz    <= lz_in;
            s1_exp   <= in_current_ex;
            s1_sum   <= in_mant_sum[MANT_W:0];
         end
      end
   end

   // Stage-2 datapath: exponent adjust and result selection by priority.
   always_comb begin
      exp_inc   = {1'b0, s1_exp} + 9'd1;
      exp_norm  = $signed({1'b0, s1_exp}) - $signed({4'b0000, s1_lz});
      // Low bits of a left shift depend only on low bits of the operand.
      frac_norm = s1_sum[MANT_W-1:0] << s1_lz;
      res_d     = FP_POS_ZERO;
      if (s1_inf) begin
         res_d = fp_inf(s1_sign);
      end else if (s1_zero) begin
         res_d = FP_POS_ZERO;
      end else if (s1_carry) begin
         if (exp_inc >= 9'd255) begin
            res_d = fp_inf(s1_sign);
         end else begin
            res_d.sign = s1_sign;
            res_d.exp  = exp_inc[EXP_W-1:0];
            res_d.frac = s1_sum[MANT_W:1];
         end
      end else if (exp_norm <= 9'sd0) begin
         res_d = fp_signed_zero(s1_sign);
      end else begin
         res_d.sign = s1_sign;
         res_d.exp  = exp_norm[EXP_W-1:0];
         res_d.frac = frac_norm;
      end
   end

   // Stage 2: register the packed result; held while downstream stalls.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s2_valid  <= 1'b0;
         s2_result <= FP_POS_ZERO;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= res_d;
         end
      end
   end

`ifdef STATUS_FLAGS_EN
   logic [2:0] flags_d;
   logic [2:0] flags_q;

   // Status flags follow the same priority as the result selection.
   always_comb begin
      flags_d = 3'b000;
      if (s1_inf) begin
         flags_d = 3'b000;
      end else if (s1_zero) begin
         flags_d = 3'b001;
      end else if (s1_carry) begin
         flags_d = (exp_inc >= 9'd255) ? 3'b100 : 3'b000;
      end else if (exp_norm <= 9'sd0) begin
         flags_d = 3'b010;
      end
   end

   // Flags register moves in lockstep with the result register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         flags_q <= 3'b000;
      end else if (s2_adv && s1_valid) begin
         flags_q <= flags_d;
      end
   end

   assign out_flags = flags_q;
`endif

endmodule

// File: doc/step3_normalize_pack.md
Name: step3_normalize_pack

Overview:
Back end of the MAC adder path. Consumes the raw aligned-mantissa sum from the pipelined adder together with the sign and exponent status carried alongside it. Normalizes the sum (carry right-shift or leading-zero left-shift), adjusts the exponent, handles zero, overflow and underflow, and packs an IEEE-754 single result. Two-stage valid/ready pipeline with backpressure, feeding the accumulator register.

Parameters:
EXP_W, 8, exponent field width
MANT_W, 23, stored fraction width; the sum input is MANT_W+2 bits (carry, hidden, fraction)

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  upstream sum and status valid
in_ready  output  1  block can accept this cycle
in_sign_in1  input  1  sign of operand 1 (delayed alongside the adder)
in_sign_in2  input  1  sign of operand 2 (delayed alongside the adder)
in_current_ex  input  8  common (larger) biased exponent
in_mant_sum  input  25  magnitude of the aligned add/sub; bit24 = carry, bit23 = hidden
in_sum_neg  input  1  1 when operand 2's magnitude won a subtraction
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_result  output  32  packed {sign, exp, frac}

Behaviour:
- Reset: asynchronous, active-low.
  - Clears stage-1 and stage-2 valid bits.
  - Clears all data registers to 0.
  - out_valid=0, out_result=0, in_ready=1 after reset.
  - Reset mid-operation discards in-flight results with no partial output.
- Handshake and latency:
  - A transfer occurs when valid && ready on a cycle.
  - Latency is 2 cycles from input transfer to out_valid with no stall. Full throughput is 1 result per cycle.
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready equals the s1-advance condition (combinational from out_ready through the pipe).
  - While out_valid=1 && out_ready=0, out_result is held stable. Order is preserved, and nothing is dropped or duplicated.
- Stage 1 (classify): registers the following.
  - Result sign: sign1 if in_sum_neg=0, else sign2.
  - Carry flag: bit24.
  - Zero flag: sum==0.
  - Inf flag: in_current_ex==8'hFF.
  - Leading-zero count lz of bits[23:0], range 0..24.
  - Exponent and sum.
- Stage 2 (normalize and pack):
  - Inf: {sign, 8'hFF, 0}.
  - Zero: 32'h00000000 (positive zero regardless of operand signs).
  - Carry: frac=sum[23:1] (truncate), exp+1.
    - If exp+1 >= 255, the result is {sign, 8'hFF, 0} (overflow).
  - Otherwise: frac=(sum<<lz)[22:0], new exponent = exp - lz, computed at 9 bits signed.
    - If the new exponent <= 0, the result is {sign, 8'h00, 0}. Denormals are flushed to zero.
  - Rounding: truncation only (round toward zero).
- Simultaneous events:
  - A new input is accepted in the same cycle s2 drains.
  - Inf takes priority over zero, which takes priority over carry.

Optional Feature:
STATUS_FLAGS_EN
- Defined:
  - Adds an output port out_flags[2:0] = {overflow, underflow, zero}.
  - Registered in stage 2 and aligned with out_result.
  - Held under stall; resets to 0.
- Undefined:
  - The port is absent and no flag logic is synthesized.
  - Result behaviour is identical either way.

Decomposition:
- Shared package fp_mac_pkg holds:
  - EXP_W, MANT_W, EXP_BIAS=127, EXP_MAX=8'hFF.
  - Packed-float typedef {sign, exp, frac}.
  - Constants for +0 and Inf.
- One sub-module is natural: lzc25, a combinational leading-zero counter (25-bit input, 5-bit count, 24 when all zero). It is instantiated in stage 1.

Test Plan:
- 1.0+1.0: ex=127, sum=25'h1000000, signs 0 -> out_result=32'h40000000 after 2 cycles.
- 1.5-1.0: ex=127, sum=25'h0400000, sign1=0, sum_neg=0 -> 32'h3F000000.
- Cancellation: sum=0, sign1=1, sign2=0 -> 32'h00000000; with STATUS_FLAGS_EN, flags=3'b001.
- Overflow: ex=254, sum=25'h1FFFFFE, signs 1 -> 32'hFF800000 (flags 3'b100). Underflow: ex=1, sum=25'h0400000 -> 32'h00000000 (flags 3'b010).
- Backpressure: 3 back-to-back inputs, out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepted.
  - out_result stays stable while stalled.
  - All 3 results emerge in order once out_ready=1.
- Reset asserted with 2 results in flight -> out_valid=0 immediately; no stale output after resetn rises.
